// File: rtl/approx_mult_seq_cfg_pkg.sv
// Shared encodings for the iterative approximate multiplier: 4x4 core modes, FSM states, digit width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package approx_mult_pkg;

   localparam int DIGIT_W = 4;

   // Per-pair behaviour of the 4x4 core; RSVD falls back to exact.
   typedef enum logic [1:0] {
      MODE_EXACT = 2'b00,
      MODE_TRUNC = 2'b01,
      MODE_ORROW = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/approx_mult_seq_cfg_mult_4x4_cfg.sv
// Configurable 4x4 digit multiplier: exact, low-bit truncated, or OR-of-partial-rows.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mult_4x4_cfg
   import approx_mult_pkg::*;
#(
   parameter int TRUNC = 2
) (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [1:0] mode,
   output logic [7:0] p
);

   // Truncation clears the TRUNC least significant product bits.
   localparam logic [7:0] TMASK = 8'(8'hFF << TRUNC);

   logic [7:0] exact;
   logic [7:0] orrow;

   // Build both candidate products, then pick by mode.
   always_comb begin
      exact = {4'b0000, a} * {4'b0000, b};
      orrow = '0;
      for (int k = 0; k < 4; k++) begin
         if (b[k]) orrow = orrow | ({4'b0000, a} << k);
      end
      p = exact;
      case (mode)
         MODE_TRUNC: p = exact & TMASK;
         MODE_ORROW: p = orrow;
         default:    p = exact;
      endcase
   end

endmodule

// File: rtl/approx_mult_seq_cfg.sv
// Iterative approximate W x W multiplier: one 4x4 digit pair per cycle, add or OR accumulation.
// Latency: handshake in cycle t -> out_valid from cycle t+K*K+1; initiation interval >= K*K+2.
// Backpressure: in_ready only in IDLE; DONE holds R and out_valid until out_ready.
module approx_mult_seq_cfg
   import approx_mult_pkg::*;
#(
   parameter int W     = 8,
   parameter int TRUNC = 2,
   parameter int SPLIT = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic [1:0]     mode_lo,
   input  logic [1:0]     mode_hi,
   input  logic           acc_or,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] R
);

   localparam int K  = W / DIGIT_W;
   localparam int NP = K * K;
   localparam int IW = $clog2(NP);
   localparam logic [IW-1:0] LAST = IW'(NP - 1);

   state_e         state, state_nx;
   logic [IW-1:0]  idx;
   logic [W-1:0]   a_q, b_q;
   logic [1:0]     mlo_q, mhi_q;
   logic           or_q;
   logic [2*W-1:0] acc, acc_nx, term;
   logic [3:0]     a_dig, b_dig;
   logic [1:0]     pair_mode;
   logic [7:0]     p;
   logic           accept;
   int             di, dj;

   assign accept = in_valid & in_ready;

   mult_4x4_cfg #(.TRUNC(TRUNC)) u_core (
      .a    (a_dig),
      .b    (b_dig),
      .mode (pair_mode),
      .p    (p)
   );

   // Select the current digit pair, place its product at 4*(i+j) and combine with the accumulator.
   always_comb begin
      di        = int'(idx) % K;
      dj        = int'(idx) / K;
      a_dig     = a_q[DIGIT_W*di +: DIGIT_W];
      b_dig     = b_q[DIGIT_W*dj +: DIGIT_W];
      pair_mode = ((di + dj) < SPLIT) ? mlo_q : mhi_q;
      term      = (2*W)'(p) << (DIGIT_W * (di + dj));
      acc_nx    = or_q ? (acc | term) : (acc + term);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (idx == LAST) state_nx = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Operand capture on accept, one accumulation step per RUN cycle, result latched on the last pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         mlo_q <= '0;
         mhi_q <= '0;
         or_q  <= 1'b0;
         acc   <= '0;
         R     <= '0;
      end else if (accept) begin
         idx   <= '0;
         a_q   <= A;
         b_q   <= B;
         mlo_q <= mode_lo;
         mhi_q <= mode_hi;
         or_q  <= acc_or;
         acc   <= '0;
      end else if (state == ST_RUN) begin
         idx <= idx + IW'(1);
         acc <= acc_nx;
         if (idx == LAST) R <= acc_nx;
      end
   end

endmodule

// File: tb/tb_approx_mult_seq_cfg.sv
// Bench for approx_mult_seq_cfg: directed table at W=8/SPLIT=1 plus random sweep at W=16/SPLIT=3.
// Latency: checks out_valid K*K+1 cycles after the handshake cycle.
// Backpressure: holds out_ready low in DONE and checks that R and the handshakes stay frozen.
module tb_approx_mult_seq_cfg;

   localparam int TR = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        iv8, ir8, ov8, ordy8, ac8;
   logic [7:0]  a8, b8;
   logic [1:0]  ml8, mh8;
   logic [15:0] r8;

   logic        iv16, ir16, ov16, ordy16, ac16;
   logic [15:0] a16, b16;
   logic [1:0]  ml16, mh16;
   logic [31:0] r16;

   approx_mult_seq_cfg #(.W(8), .TRUNC(TR), .SPLIT(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
      .mode_lo(ml8), .mode_hi(mh8), .acc_or(ac8), .out_valid(ov8), .out_ready(ordy8), .R(r8));

   approx_mult_seq_cfg #(.W(16), .TRUNC(TR), .SPLIT(3)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
      .mode_lo(ml16), .mode_hi(mh16), .acc_or(ac16), .out_valid(ov16), .out_ready(ordy16), .R(r16));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: sum/OR of each digit product weighted by 16^(i+j), digit products from the mode rules.
   function automatic longint unsigned ref_mult(input longint unsigned a, input longint unsigned b,
                                                input int w, input int split, input int mlo,
                                                input int mhi, input bit accor);
      int k = w / 4;
      longint unsigned res = 0;
      longint unsigned da, db, p;
      int md;
      for (int i = 0; i < k; i++) begin
         for (int j = 0; j < k; j++) begin
            da = (a >> (4 * i)) % 16;
            db = (b >> (4 * j)) % 16;
            md = (i + j < split) ? mlo : mhi;
            if (md == 1) p = ((da * db) / (1 << TR)) * (1 << TR);
            else if (md == 2) begin
               p = 0;
               for (int t = 0; t < 4; t++) if (((db >> t) % 2) == 1) p = p | (da << t);
            end else p = da * db;
            p = p * (64'd1 << (4 * (i + j)));
            res = accor ? (res | p) : (res + p);
         end
      end
      return res;
   endfunction

   // Present an operation and wait for the handshake cycle (returns just before the accepting edge).
   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] ml,
                         input logic [1:0] mh, input logic ac);
      int n = 0;
      @(negedge clk);
      a8 = a; b8 = b; ml8 = ml; mh8 = mh; ac8 = ac; iv8 = 1'b1;
      while (!ir8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL accept8_timeout: in_ready stayed %0b, required 1", ir8);
      end
   endtask

   // From the handshake cycle: scramble inputs, count cycles to out_valid, optionally release.
   task automatic finish8(output logic [15:0] r, output int lat, input bit release_out);
      @(negedge clk);
      iv8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); ml8 = 2'($urandom); mh8 = 2'($urandom); ac8 = 1'($urandom);
      lat = 1;
      while (!ov8 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 100) begin
         checks++; errors++;
         $display("FAIL done8_timeout: out_valid stayed %0b, required 1", ov8);
      end
      r = r8;
      if (release_out) begin
         ordy8 = 1'b1;
         @(negedge clk);
         ordy8 = 1'b0;
      end
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] ml,
                       input logic [1:0] mh, input logic ac, output logic [31:0] r, output int lat);
      int n = 0;
      @(negedge clk);
      a16 = a; b16 = b; ml16 = ml; mh16 = mh; ac16 = ac; iv16 = 1'b1;
      while (!ir16 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      iv16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
      lat = 1;
      while (!ov16 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (n >= 50 || lat >= 200) begin
         checks++; errors++;
         $display("FAIL op16_timeout: in_ready %0b out_valid %0b, required both seen high", ir16, ov16);
      end
      r = r16;
      ordy16 = 1'b1;
      @(negedge clk);
      ordy16 = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  a, b;
      logic [1:0]  ml, mh;
      logic        ac;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [15:0] r;
      logic [31:0] r32;
      int lat;
      longint unsigned expv;

      tbl[0] = '{8'hFF, 8'hFF, 2'b00, 2'b00, 1'b0, 16'hFE01};
      tbl[1] = '{8'hFF, 8'hFF, 2'b00, 2'b00, 1'b1, 16'hEFF1};
      tbl[2] = '{8'hFF, 8'hFF, 2'b01, 2'b00, 1'b0, 16'hFE00};
      tbl[3] = '{8'h03, 8'h03, 2'b10, 2'b00, 1'b0, 16'h0007};
      tbl[4] = '{8'h03, 8'h03, 2'b00, 2'b00, 1'b0, 16'h0009};

      rst = 1'b1;
      iv8 = 0; ordy8 = 0; a8 = 0; b8 = 0; ml8 = 0; mh8 = 0; ac8 = 0;
      iv16 = 0; ordy16 = 0; a16 = 0; b16 = 0; ml16 = 0; mh16 = 0; ac16 = 0;
      @(negedge clk);
      check("reset_in_ready", 64'(ir8), 64'd1);
      check("reset_out_valid", 64'(ov8), 64'd0);
      check("reset_r", 64'(r8), 64'd0);
      check("reset_in_ready16", 64'(ir16), 64'd1);
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         start8(tbl[v].a, tbl[v].b, tbl[v].ml, tbl[v].mh, tbl[v].ac);
         finish8(r, lat, 1'b1);
         check($sformatf("table%0d_r", v), 64'(r), 64'(tbl[v].exp));
         check($sformatf("table%0d_latency", v), 64'(lat), 64'd5);
      end

      // Hold the result under backpressure while a new request waits.
      start8(8'hFF, 8'hFF, 2'b00, 2'b00, 1'b0);
      finish8(r, lat, 1'b0);
      iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ml8 = 2'b00; mh8 = 2'b00; ac8 = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("hold_out_valid", 64'(ov8), 64'd1);
         check("hold_r", 64'(r8), 64'hFE01);
         check("hold_in_ready", 64'(ir8), 64'd0);
      end
      ordy8 = 1'b1;
      @(negedge clk);
      ordy8 = 1'b0;
      check("release_out_valid", 64'(ov8), 64'd0);
      check("release_in_ready", 64'(ir8), 64'd1);
      finish8(r, lat, 1'b1);
      check("after_hold_r", 64'(r), 64'h03A8);
      check("after_hold_latency", 64'(lat), 64'd5);

      // Abort mid-run at pair index 2.
      start8(8'hFF, 8'hFF, 2'b00, 2'b00, 1'b0);
      @(negedge clk);
      iv8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_out_valid", 64'(ov8), 64'd0);
      check("abort_r", 64'(r8), 64'd0);
      check("abort_in_ready", 64'(ir8), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      start8(8'hA5, 8'h3C, 2'b00, 2'b00, 1'b0);
      finish8(r, lat, 1'b1);
      check("after_abort_r", 64'(r), 64'(16'hA5 * 16'h3C));

      // Random sweep, W=16 SPLIT=3, every mode_lo/mode_hi/acc_or combination twice.
      for (int it = 0; it < 64; it++) begin
         logic [15:0] ra, rb;
         logic [1:0]  rml, rmh;
         logic        rac;
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         if (it == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; end
         rml = 2'(it % 4);
         rmh = 2'((it / 4) % 4);
         rac = 1'((it / 16) % 2);
         expv = ref_mult(64'(ra), 64'(rb), 16, 3, int'(rml), int'(rmh), rac);
         op16(ra, rb, rml, rmh, rac, r32, lat);
         check($sformatf("rand%0d_r a=%h b=%h m=%0d/%0d or=%0b", it, ra, rb, rml, rmh, rac),
               64'(r32), 64'(expv));
         if (it % 16 == 0) check("rand_latency", 64'(lat), 64'd17);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
